// File: rtl/game_pkg.sv
// Shared definitions for the board-game turn datapath: player indices, draw palette,
// turn FSM states and width helpers.
package game_pkg;

  localparam int unsigned MAX_PLAYERS       = 8;
  localparam int unsigned DEFAULT_MAX_MOVES = 60;

  localparam logic [2:0] PLAYER_BLACK = 3'd0;
  localparam logic [2:0] PLAYER_WHITE = 3'd1;

  // Entries 0 and 1 are overridden to all-zeros / all-ones at any colour width.
  localparam logic [7:0] PALETTE [MAX_PLAYERS] = '{
    8'h00, 8'hff, 8'h04, 8'h02, 8'h01, 8'h06, 8'h05, 8'h03
  };

  typedef enum logic [1:0] {
    StStart,
    StWait,
    StOver
  } turn_state_e;

  function automatic int unsigned player_w(int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Turn control bundle between the commit logic, the turn sequencer and the draw path.
interface turn_sequencer_if
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned COLOUR_W    = 3,
  parameter int unsigned MAX_MOVES   = DEFAULT_MAX_MOVES
);

  localparam int unsigned PW = player_w(NUM_PLAYERS);
  localparam int unsigned MW = $clog2(MAX_MOVES + 1);

  logic                new_game;
  logic                turn_done;
  logic                pass_req;
  logic                turn_start;
  logic [PW-1:0]       cur_player;
  logic [COLOUR_W-1:0] cur_colour;
  logic [MW-1:0]       move_count;
  logic [PW:0]         pass_count;
  logic                game_over;

  modport master (
    output new_game,
    output turn_done,
    output pass_req,
    input  turn_start,
    input  cur_player,
    input  cur_colour,
    input  move_count,
    input  pass_count,
    input  game_over
  );

  modport slave (
    input  new_game,
    input  turn_done,
    input  pass_req,
    output turn_start,
    output cur_player,
    output cur_colour,
    output move_count,
    output pass_count,
    output game_over
  );

endinterface

// File: rtl/player_palette.sv
// Combinational player index to draw colour lookup; also used for static pieces.
module player_palette
  import game_pkg::*;
#(
  parameter int unsigned PW       = 1,
  parameter int unsigned COLOUR_W = 3
) (
  input  logic [PW-1:0]       player,
  output logic [COLOUR_W-1:0] colour
);

  logic [2:0] idx;

  always_comb begin
    idx = 3'(player);
    if (idx == PLAYER_BLACK) begin
      colour = '0;
    end else if (idx == PLAYER_WHITE) begin
      colour = '1;
    end else begin
      colour = COLOUR_W'(PALETTE[idx]);
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Rotating turn controller: tracks the player to move, committed moves and consecutive
// passes, strobes turn_start for the move-validity engine and flags end of game.
module turn_sequencer
  import game_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned COLOUR_W     = 3,
  parameter int unsigned MAX_MOVES    = DEFAULT_MAX_MOVES,
  parameter int unsigned FIRST_PLAYER = 0
) (
  input  logic              clk,
  input  logic              resetn,
  turn_sequencer_if.slave   bus
);

  localparam int unsigned PW = player_w(NUM_PLAYERS);
  localparam int unsigned MW = $clog2(MAX_MOVES + 1);

  localparam logic [PW-1:0] FirstPlayer = PW'(FIRST_PLAYER);
  localparam logic [PW-1:0] LastPlayer  = PW'(NUM_PLAYERS - 1);
  localparam logic [MW-1:0] MoveLimit   = MW'(MAX_MOVES);
  localparam logic [PW:0]   PassLimit   = (PW + 1)'(NUM_PLAYERS);

  turn_state_e   state_q, state_d;
  logic          primed_q, primed_d;
  logic [PW-1:0] player_q, player_d;
  logic [MW-1:0] moves_q, moves_d;
  logic [PW:0]   passes_q, passes_d;
  logic [PW-1:0] player_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StStart;
      primed_q <= 1'b0;
      player_q <= FirstPlayer;
      moves_q  <= '0;
      passes_q <= '0;
    end else begin
      state_q  <= state_d;
      primed_q <= primed_d;
      player_q <= player_d;
      moves_q  <= moves_d;
      passes_q <= passes_d;
    end
  end

  assign player_next = (player_q == LastPlayer) ? '0 : player_q + PW'(1);

  // After reset or new_game START is entered unprimed: it spends one quiet cycle
  // arming before the strobe, so turn_start never coincides with the restart edge.
  always_comb begin
    state_d  = state_q;
    primed_d = primed_q;
    player_d = player_q;
    moves_d  = moves_q;
    passes_d = passes_q;

    if (bus.new_game) begin
      state_d  = StStart;
      primed_d = 1'b0;
      player_d = FirstPlayer;
      moves_d  = '0;
      passes_d = '0;
    end else begin
      unique case (state_q)
        StStart: begin
          if (primed_q) begin
            state_d = StWait;
          end else begin
            primed_d = 1'b1;
          end
        end
        StWait: begin
          if (bus.turn_done) begin
            player_d = player_next;
            moves_d  = moves_q + MW'(1);
            passes_d = '0;
            state_d  = (moves_d == MoveLimit) ? StOver : StStart;
          end else if (bus.pass_req) begin
            player_d = player_next;
            passes_d = passes_q + (PW + 1)'(1);
            state_d  = (passes_d == PassLimit) ? StOver : StStart;
          end
        end
        StOver: begin
        end
        default: begin
          state_d = StStart;
        end
      endcase
    end
  end

  always_comb begin
    bus.turn_start = (state_q == StStart) && primed_q;
    bus.game_over  = (state_q == StOver);
  end

  assign bus.cur_player = player_q;
  assign bus.move_count = moves_q;
  assign bus.pass_count = passes_q;

  player_palette #(
    .PW       (PW),
    .COLOUR_W (COLOUR_W)
  ) u_palette (
    .player (player_q),
    .colour (bus.cur_colour)
  );

endmodule
